// File: rtl/instr_src_pkg.sv
// Shared mode encoding and default constants for the instruction source controller.
package instr_src_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_MANUAL = 2'b00;
  localparam logic [MODE_W-1:0] MODE_RUN    = 2'b01;
  localparam logic [MODE_W-1:0] MODE_STEP   = 2'b10;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

  // The unused encoding 2'b11 is treated as MANUAL.
  function automatic logic [MODE_W-1:0] decodeMode(input logic [MODE_W-1:0] m);
    return (m == MODE_RUN || m == MODE_STEP) ? m : MODE_MANUAL;
  endfunction

  function automatic logic [MODE_W-1:0] nextMode(input logic [MODE_W-1:0] m);
    case (decodeMode(m))
      MODE_MANUAL: return MODE_RUN;
      MODE_RUN:    return MODE_STEP;
      default:     return MODE_MANUAL;
    endcase
  endfunction

endpackage

// File: rtl/debounce_edge.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle rising-edge pulse.
module debounce_edge
  import instr_src_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CntWidth = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE_CYCLES - 1);

  logic [1:0]          syncQ;
  logic [CntWidth-1:0] cntQ, cntD;
  logic                levelQ, levelD;
  logic                riseQ, riseD;

  // The counter holds how many consecutive cycles the synchronised level has disagreed.
  always_comb begin
    cntD   = cntQ;
    levelD = levelQ;
    riseD  = 1'b0;
    if (syncQ[1] != levelQ) begin
      if (cntQ == CntLast) begin
        levelD = syncQ[1];
        cntD   = '0;
        riseD  = syncQ[1];
      end else begin
        cntD = cntQ + 1'b1;
      end
    end else begin
      cntD = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      syncQ  <= '0;
      cntQ   <= '0;
      levelQ <= 1'b0;
      riseQ  <= 1'b0;
    end else begin
      syncQ  <= {syncQ[0], btn_raw};
      cntQ   <= cntD;
      levelQ <= levelD;
      riseQ  <= riseD;
    end
  end

  assign level = levelQ;
  assign rise  = riseQ;

endmodule

// File: rtl/instr_source_ctrl.sv
// Selects ROM or switch instructions for the CPU and gates its clock enable
// according to the MANUAL / RUN / STEP mode.
module instr_source_ctrl
  import instr_src_pkg::*;
#(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_btn,
  input  logic              step_btn,
  input  logic [DATA_W-1:0] switches,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_en,
  output logic [MODE_W-1:0] mode,
  output logic [CNT_W-1:0]  exec_count
);

  logic modeLevel, modeRiseRaw, modeRise;
  logic stepLevel, stepRiseRaw, stepRise;

  debounce_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_modeDebounce (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(mode_btn),
    .level  (modeLevel),
    .rise   (modeRiseRaw)
  );

  debounce_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_stepDebounce (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(step_btn),
    .level  (stepLevel),
    .rise   (stepRiseRaw)
  );

  // A rise is only ever issued together with an accepted high level.
  assign modeRise = modeRiseRaw & modeLevel;
  assign stepRise = stepRiseRaw & stepLevel;

  logic [MODE_W-1:0] modeQ, modeD, curMode;
  logic [DATA_W-1:0] instrRegQ, instrRegD;
  logic              stepPulseQ, stepPulseD;
  logic [CNT_W-1:0]  execCountQ, execCountD;

  assign curMode = decodeMode(modeQ);

  // A mode press takes priority; a simultaneous step press is dropped.
  always_comb begin
    modeD      = curMode;
    instrRegD  = instrRegQ;
    stepPulseD = 1'b0;
    execCountD = execCountQ;
    if (cpu_en) begin
      execCountD = execCountQ + 1'b1;
    end
    if (modeRise) begin
      modeD = nextMode(curMode);
    end else if (stepRise) begin
      case (curMode)
        MODE_MANUAL: begin
          instrRegD  = switches;
          stepPulseD = 1'b1;
        end
        MODE_STEP: stepPulseD = 1'b1;
        default:   stepPulseD = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      modeQ      <= MODE_MANUAL;
      instrRegQ  <= '0;
      stepPulseQ <= 1'b0;
      execCountQ <= '0;
    end else begin
      modeQ      <= modeD;
      instrRegQ  <= instrRegD;
      stepPulseQ <= stepPulseD;
      execCountQ <= execCountD;
    end
  end

  always_comb begin
    cpu_en      = !reset && ((curMode == MODE_RUN) || stepPulseQ);
    instruction = (curMode == MODE_MANUAL) ? instrRegQ : rom_data;
  end

  assign mode       = curMode;
  assign exec_count = execCountQ;

endmodule

// File: tb/tb_instr_source_ctrl.sv
// Randomised bench for instr_source_ctrl against a history-based behavioural model.
module tb_instr_source_ctrl;

  localparam int unsigned DataW  = 16;
  localparam int unsigned Deb    = 4;
  localparam int unsigned CntW   = 4;
  localparam int          MaxCyc = 4096;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mode_btn = 1'b0;
  logic             step_btn = 1'b0;
  logic [DataW-1:0] switches = '0;
  logic [DataW-1:0] rom_data = '0;
  logic [DataW-1:0] instruction;
  logic             cpu_en;
  logic [1:0]       mode;
  logic [CntW-1:0]  exec_count;

  always #5 clk = ~clk;

  instr_source_ctrl #(
    .DATA_W         (DataW),
    .DEBOUNCE_CYCLES(Deb),
    .CNT_W          (CntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_btn   (mode_btn),
    .step_btn   (step_btn),
    .switches   (switches),
    .rom_data   (rom_data),
    .instruction(instruction),
    .cpu_en     (cpu_en),
    .mode       (mode),
    .exec_count (exec_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state. Buttons: index 0 = mode, 1 = step.
  int          mMode = 0;
  logic [15:0] mInstr = '0;
  bit          mPulse = 0;
  int          mCount = 0;
  bit          mRise[2];
  bit          mLevel[2];
  int          lastFlip[2];
  int          lastReset = -10;
  bit          rawLog[2][MaxCyc];
  int          cyc = 0;
  bit          armed = 0;
  bit          curRst = 1;
  logic [15:0] curRom = '0;
  logic [15:0] swNext = '0;

  // Synchronised level seen at edge j: raw sample from two edges earlier, zero across reset.
  function automatic bit synced(input int b, input int j);
    if (j - 2 <= lastReset) return 1'b0;
    return rawLog[b][j-2];
  endfunction

  // Accepted level flips once the last Deb synced samples since the previous flip all differ.
  function automatic bit debStep(input int b, input int k);
    int lo = k - int'(Deb) + 1;
    bit flip = 0;
    if (lo > lastFlip[b] && lo > lastReset) begin
      flip = 1;
      for (int j = lo; j <= k; j++) if (synced(b, j) == mLevel[b]) flip = 0;
    end
    if (!flip) return 1'b0;
    mLevel[b]   = !mLevel[b];
    lastFlip[b] = k;
    return mLevel[b];
  endfunction

  task automatic modelEdge(input bit rst, input bit mb, input bit sb, input logic [15:0] sw);
    int k = cyc;
    rawLog[0][k] = mb;
    rawLog[1][k] = sb;
    if (rst) begin
      mMode = 0; mInstr = '0; mPulse = 0; mCount = 0;
      lastReset = k;
      for (int b = 0; b < 2; b++) begin
        mRise[b] = 0; mLevel[b] = 0; lastFlip[b] = k;
      end
    end else begin
      if (mMode == 1 || mPulse) mCount = (mCount + 1) % (1 << CntW);
      if (mRise[0]) begin
        mMode  = (mMode + 1) % 3;
        mPulse = 0;
      end else if (mRise[1] && mMode == 2) begin
        mPulse = 1;
      end else if (mRise[1] && mMode == 0) begin
        mInstr = sw;
        mPulse = 1;
      end else begin
        mPulse = 0;
      end
      mRise[0] = debStep(0, k);
      mRise[1] = debStep(1, k);
    end
  endtask

  // One clock: compare at the negedge, drive new inputs, advance the model past the next posedge.
  task automatic cycle(input bit mb, input bit sb, input bit rst);
    @(negedge clk);
    if (armed) begin
      checkVal("mode", 32'(mode), 32'(mMode));
      checkVal("cpu_en", 32'(cpu_en), 32'(!curRst && (mMode == 1 || mPulse)));
      checkVal("instruction", 32'(instruction), 32'((mMode == 0) ? mInstr : curRom));
      checkVal("exec_count", 32'(exec_count), 32'(mCount));
    end
    mode_btn = mb;
    step_btn = sb;
    reset    = rst;
    switches = swNext;
    rom_data = 16'($urandom);
    curRst   = rst;
    curRom   = rom_data;
    if (cyc < MaxCyc) modelEdge(rst, mb, sb, swNext);
    cyc++;
    armed = 1;
  endtask

  task automatic hold(input bit mb, input bit sb, input int n, input bit rst);
    for (int i = 0; i < n; i++) cycle(mb, sb, rst);
  endtask

  // Clean press preceded by a short random glitch.
  task automatic press(input int which);
    int g = int'($urandom_range(1, 3));
    hold(which == 0, which == 1, g, 0);
    hold(0, 0, 8, 0);
    hold(which == 0, which == 1, 8, 0);
    hold(0, 0, 8, 0);
  endtask

  task automatic gotoMode(input int target);
    for (int t = 0; t < 4 && mMode != target; t++) press(0);
    checkVal("gotoMode", 32'(mode), 32'(target));
  endtask

  initial begin
    int cntBefore;
    bit mb, sb;

    // Reset and idle values.
    hold(0, 0, 2, 1);
    cycle(0, 0, 0);
    checkVal("rst_mode", 32'(mode), 32'd0);
    checkVal("rst_cpu_en", 32'(cpu_en), 32'd0);
    checkVal("rst_instr", 32'(instruction), 32'd0);
    checkVal("rst_count", 32'(exec_count), 32'd0);

    // Glitches of 1..3 cycles, then a held press: mode changes on the 7th edge.
    for (int g = 1; g <= 3; g++) begin
      hold(1, 0, g, 0);
      hold(0, 0, 8, 0);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0);
      if (i == 6) checkVal("latency_before", 32'(mode), 32'd0);
      if (i == 7) checkVal("latency_after", 32'(mode), 32'd1);
    end
    hold(0, 0, 6, 0);
    checkVal("run_cpu_en", 32'(cpu_en), 32'd1);

    // Manual step latches switches; later switch changes are invisible.
    gotoMode(0);
    swNext = 16'h0007;
    cntBefore = mCount;
    press(1);
    swNext = 16'h1234;
    hold(0, 0, 4, 0);
    checkVal("manual_instr", 32'(instruction), 32'h0007);
    checkVal("manual_count", 32'(exec_count), 32'((cntBefore + 1) % (1 << CntW)));

    // Step mode: three presses, then a long hold.
    gotoMode(2);
    cntBefore = mCount;
    for (int p = 0; p < 3; p++) press(1);
    checkVal("step_count", 32'(exec_count), 32'((cntBefore + 3) % (1 << CntW)));
    cntBefore = mCount;
    hold(0, 1, 50, 0);
    hold(0, 0, 8, 0);
    checkVal("step_hold", 32'(exec_count), 32'((cntBefore + 1) % (1 << CntW)));

    // Simultaneous presses in MANUAL: mode wins.
    gotoMode(0);
    swNext = 16'hBEEF;
    hold(1, 1, 8, 0);
    hold(0, 0, 8, 0);
    checkVal("simul_mode", 32'(mode), 32'd1);
    gotoMode(0);
    checkVal("simul_instr", 32'(instruction), 32'h0007);

    // Counter wrap in RUN, then reset in the middle of a step debounce.
    hold(0, 0, 2, 1);
    for (int t = 0; t < 20 && mMode != 1; t++) cycle(1, 0, 0);
    hold(0, 0, 17, 0);
    cycle(0, 0, 0);
    checkVal("wrap_count", 32'(exec_count), 32'd1);
    hold(0, 1, 3, 0);
    hold(0, 1, 2, 1);
    cycle(0, 1, 0);
    checkVal("post_rst_mode", 32'(mode), 32'd0);
    checkVal("post_rst_count", 32'(exec_count), 32'd0);
    hold(0, 1, 10, 0);
    hold(0, 0, 8, 0);

    // Random bouncy buttons with occasional resets.
    mb = 0;
    sb = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) mb = !mb;
      if ($urandom_range(0, 3) == 0) sb = !sb;
      swNext = 16'($urandom);
      cycle(mb, sb, $urandom_range(0, 63) == 0);
    end
    hold(0, 0, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
